cla_addsub_seq: RTL and testbench
=================================

// Module: cla_addsub_seq
// PURPOSE
//  Multi-cycle, parametrised add/subtract unit built around one CHUNK-bit carry-lookahead slice.
//  A WIDTH-bit operation runs as NCHUNK = WIDTH/CHUNK slices, LSB slice first, one slice per clock.
//  A carry register chains the slices; it adds a subtract mode and N/Z/C/V-style flags.
//  Sits beside the ALU for wide or area-constrained arithmetic, using a start/busy/done handshake.
// PARAMETERS
//  WIDTH  32  operand/result width; must be a multiple of CHUNK (otherwise elaboration error)
//  CHUNK   8  CLA slice width processed per cycle; 1 <= CHUNK <= WIDTH
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; accepted only in IDLE
//  sub    in   1      0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored); sampled with start
//  a      in   WIDTH  operand A, sampled on accepted start
//  b      in   WIDTH  operand B, sampled on accepted start
//  cin    in   1      carry-in for add, sampled on accepted start
//  busy   out  1      high while state==BUSY
//  done   out  1      one-cycle pulse; results valid from this cycle
//  sum    out  WIDTH  result, registered
//  cout   out  1      carry out of MSB (for sub: 1 = no borrow)
//  ovf    out  1      signed overflow = carry into MSB ^ carry out of MSB
//  zero   out  1      sum == 0
// BEHAVIOUR
//  Reset (rst=1 at an edge): state<=IDLE, slice counter<=0, carry<=0.
//   sum/cout/ovf/zero/done<=0, so busy=0.
//   Reset in mid-operation aborts the operation; no done is produced.
//  FSM: IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: at edge E0 with start=1, latch a, (sub ? ~b : b), and carry<=(sub ? 1 : cin).
//    Also set cnt<=0 and state<=BUSY. start=0 stays in IDLE.
//   BUSY: at edges E1..E_NCHUNK, compute slice cnt with CLA logic (g=a&b, p=a^b, chained c).
//    Write the slice into the internal accumulator; carry<=slice carry-out; cnt<=cnt+1.
//    At edge E_NCHUNK (cnt==NCHUNK-1), load sum/cout/ovf/zero from the accumulator and state<=DONE.
//    Set done<=1 at the same edge.
//    ovf uses the carry into bit WIDTH-1, taken inside the last slice.
//   DONE: lasts one cycle; at the next edge done<=0 and state<=IDLE.
//  Latency: done is high in the cycle that begins NCHUNK edges after the start edge.
//   Issue interval is NCHUNK+2 cycles.
//  start in BUSY or DONE is ignored (not queued); a, b, sub, cin may change freely after E0.
//  sum/cout/ovf/zero hold their last result until the next completion or reset.
//   They do not change during BUSY: no partial results are visible.
//  CHUNK==WIDTH gives NCHUNK=1: one BUSY cycle, done one cycle after the start edge.
//  Counter width is clog2(NCHUNK), minimum 1 bit; no wrap beyond NCHUNK-1.
//  Slice carry chain is pure lookahead within a slice (no ripple between registers across slices).
// TESTING (WIDTH=32, CHUNK=8 unless noted)
//  add a=FFFFFFFF b=00000001 cin=0 -> sum=00000000 cout=1 zero=1 ovf=0.
//   done exactly 4 cycles after start edge; busy high 4 cycles.
//  sub a=00000005 b=00000007 -> sum=FFFFFFFE cout=0 ovf=0 zero=0.
//   sub a=80000000 b=00000001 -> sum=7FFFFFFF ovf=1 cout=1.
//  add a=7FFFFFFF b=00000001 -> sum=80000000 ovf=1 cout=0.
//   add a=000000FF b=0 cin=1 -> sum=00000100 (inter-slice carry).
//  start held high during BUSY/DONE with changing operands -> only the first op completes.
//   Exactly one done pulse; outputs stay stable during BUSY.
//  rst at 2nd BUSY cycle -> next cycle busy=0, sum=0, flags=0, no done.
//   A subsequent start 00000001+00000001 -> sum=00000002.
//  sweep CHUNK in {1,4,8,32} with 1000 random ops each vs a+b+cin / a-b golden model.
//   Includes latency check (NCHUNK) and flags.

Source files
------------

// File: rtl/cla_addsub_seq.sv
// Multi-cycle add/subtract unit: one CHUNK-bit carry-lookahead slice per clock, LSB slice first,
// with a carry register chaining slices and N/Z/C/V-style result flags.
module cla_addsub_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_sub,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf,
   output logic             o_zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   generate
      if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("cla_addsub_seq: WIDTH must be a non-zero multiple of CHUNK");
      end
   endgenerate

   // state  | meaning
   // IDLE   | waiting for start; operands latched on accept
   // BUSY   | one slice per cycle, slice index in r_cnt
   // DONE   | results just loaded, done pulse high
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   logic [CHUNK-1:0] w_g;
   logic [CHUNK-1:0] w_p;
   logic [CHUNK:0]   w_c;
   logic [CHUNK-1:0] w_s;
   logic [WIDTH-1:0] w_a_nxt;
   logic [WIDTH-1:0] w_b_nxt;
   logic [WIDTH-1:0] w_acc_nxt;

   assign w_g = r_a[CHUNK-1:0] & r_b[CHUNK-1:0];
   assign w_p = r_a[CHUNK-1:0] ^ r_b[CHUNK-1:0];

   // Each carry is the flattened generate/propagate sum, not a ripple through w_c.
   always_comb begin
      logic v_gen;
      logic v_prop;
      v_gen  = 1'b0;
      v_prop = 1'b1;
      w_c    = '0;
      w_c[0] = r_carry;
      for (int i = 0; i < CHUNK; i++) begin
         v_gen  = 1'b0;
         v_prop = 1'b1;
         for (int j = i; j >= 0; j--) begin
            v_gen  = v_gen | (v_prop & w_g[j]);
            v_prop = v_prop & w_p[j];
         end
         w_c[i+1] = v_gen | (v_prop & r_carry);
      end
   end

   assign w_s = w_p ^ w_c[CHUNK-1:0];

   // Operands shift down one slice per cycle; the accumulator fills from the top.
   generate
      if (NCHUNK > 1) begin : g_multi
         logic [WIDTH-1:0] r_acc;

         assign w_a_nxt   = {{CHUNK{1'b0}}, r_a[WIDTH-1:CHUNK]};
         assign w_b_nxt   = {{CHUNK{1'b0}}, r_b[WIDTH-1:CHUNK]};
         assign w_acc_nxt = {w_s, r_acc[WIDTH-1:CHUNK]};

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_acc <= '0;
            end else if (r_state == S_BUSY) begin
               r_acc <= w_acc_nxt;
            end
         end
      end else begin : g_single
         assign w_a_nxt   = r_a;
         assign w_b_nxt   = r_b;
         assign w_acc_nxt = w_s;
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_a     <= i_a;
                  r_b     <= i_sub ? ~i_b : i_b;
                  r_carry <= i_sub ? 1'b1 : i_cin;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_a     <= w_a_nxt;
               r_b     <= w_b_nxt;
               r_carry <= w_c[CHUNK];
               if (r_cnt == LAST) begin
                  r_cnt   <= '0;
                  r_sum   <= w_acc_nxt;
                  r_cout  <= w_c[CHUNK];
                  r_ovf   <= w_c[CHUNK] ^ w_c[CHUNK-1];
                  r_zero  <= (w_acc_nxt == '0);
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_sum  = r_sum;
   assign o_cout = r_cout;
   assign o_ovf  = r_ovf;
   assign o_zero = r_zero;

endmodule

// File: tb/tb_cla_addsub_seq.sv
// Bench for cla_addsub_seq: four instances (CHUNK 1/4/8/32, WIDTH 32) checked against an
// arithmetic reference model built on 64-bit integers.
module tb_cla_addsub_seq;

   localparam int WAIT_MAX = 64;

   logic        clk;
   logic        rst;
   logic        start_v [4];
   logic        sub_v   [4];
   logic        cin_v   [4];
   logic [31:0] a_v     [4];
   logic [31:0] b_v     [4];
   logic        busy_v  [4];
   logic        done_v  [4];
   logic [31:0] sum_v   [4];
   logic        cout_v  [4];
   logic        ovf_v   [4];
   logic        zero_v  [4];

   int errors = 0;
   int checks = 0;

   cla_addsub_seq #(.WIDTH(32), .CHUNK(1)) u_dut_c1 (
      .i_clk(clk), .i_rst(rst), .i_start(start_v[0]), .i_sub(sub_v[0]), .i_a(a_v[0]),
      .i_b(b_v[0]), .i_cin(cin_v[0]), .o_busy(busy_v[0]), .o_done(done_v[0]),
      .o_sum(sum_v[0]), .o_cout(cout_v[0]), .o_ovf(ovf_v[0]), .o_zero(zero_v[0]));

   cla_addsub_seq #(.WIDTH(32), .CHUNK(4)) u_dut_c4 (
      .i_clk(clk), .i_rst(rst), .i_start(start_v[1]), .i_sub(sub_v[1]), .i_a(a_v[1]),
      .i_b(b_v[1]), .i_cin(cin_v[1]), .o_busy(busy_v[1]), .o_done(done_v[1]),
      .o_sum(sum_v[1]), .o_cout(cout_v[1]), .o_ovf(ovf_v[1]), .o_zero(zero_v[1]));

   cla_addsub_seq #(.WIDTH(32), .CHUNK(8)) u_dut_c8 (
      .i_clk(clk), .i_rst(rst), .i_start(start_v[2]), .i_sub(sub_v[2]), .i_a(a_v[2]),
      .i_b(b_v[2]), .i_cin(cin_v[2]), .o_busy(busy_v[2]), .o_done(done_v[2]),
      .o_sum(sum_v[2]), .o_cout(cout_v[2]), .o_ovf(ovf_v[2]), .o_zero(zero_v[2]));

   cla_addsub_seq #(.WIDTH(32), .CHUNK(32)) u_dut_c32 (
      .i_clk(clk), .i_rst(rst), .i_start(start_v[3]), .i_sub(sub_v[3]), .i_a(a_v[3]),
      .i_b(b_v[3]), .i_cin(cin_v[3]), .o_busy(busy_v[3]), .o_done(done_v[3]),
      .o_sum(sum_v[3]), .o_cout(cout_v[3]), .o_ovf(ovf_v[3]), .o_zero(zero_v[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on the full-width values.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                 input logic cin, output logic [31:0] s, output logic c,
                                 output logic v, output logic z);
      longint ua, ub, ur, sa, sb, sr;
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sub) begin
         ur = ua - ub;
         c  = (ua >= ub);
         sr = sa - sb;
      end else begin
         ur = ua + ub + longint'(cin);
         c  = (ur > 64'sd4294967295);
         sr = sa + sb + longint'(cin);
      end
      s = ur[31:0];
      v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      z = (s == 32'd0);
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Runs one operation on instance k starting at a negedge; returns observations, ends at a negedge.
   task automatic drive_op(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic cin,
                           output int lat, output int busyc, output bit stable,
                           output logic [31:0] s, output logic c, output logic v,
                           output logic z, output logic busy_at_done, output logic done_after);
      logic [31:0] prev_s;
      logic        prev_c, prev_v, prev_z;
      prev_s = sum_v[k];
      prev_c = cout_v[k];
      prev_v = ovf_v[k];
      prev_z = zero_v[k];
      start_v[k] = 1'b1;
      a_v[k]     = a;
      b_v[k]     = b;
      sub_v[k]   = sub;
      cin_v[k]   = cin;
      @(negedge clk);
      start_v[k] = 1'b0;
      a_v[k]     = $urandom;
      b_v[k]     = $urandom;
      sub_v[k]   = 1'($urandom);
      cin_v[k]   = 1'($urandom);
      lat    = 0;
      busyc  = 0;
      stable = 1'b1;
      while (done_v[k] !== 1'b1 && lat < WAIT_MAX) begin
         if (busy_v[k] === 1'b1) busyc++;
         if (sum_v[k] !== prev_s || cout_v[k] !== prev_c || ovf_v[k] !== prev_v ||
             zero_v[k] !== prev_z) stable = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (done_v[k] !== 1'b1) lat = -1;
      s            = sum_v[k];
      c            = cout_v[k];
      v            = ovf_v[k];
      z            = zero_v[k];
      busy_at_done = busy_v[k];
      @(negedge clk);
      done_after = done_v[k];
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl[%0d]: got busy=%b done=%b exp 0 0", k, busy_v[k], done_v[k]);
         end
         checks++;
         if (sum_v[k] !== 32'h0 || cout_v[k] !== 1'b0 || ovf_v[k] !== 1'b0 || zero_v[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset_out[%0d]: got sum=%h c=%b v=%b z=%b exp 0", k, sum_v[k],
                     cout_v[k], ovf_v[k], zero_v[k]);
         end
      end
   endtask

   task automatic test_vectors();
      logic [31:0] va [7];
      logic [31:0] vb [7];
      logic        vsub [7];
      logic        vcin [7];
      logic [31:0] es [7];
      logic        ec [7];
      logic        ev [7];
      logic        ez [7];
      int lat, busyc;
      bit stable;
      logic [31:0] s;
      logic c, v, z, bd, da;
      va[0]=32'hFFFFFFFF; vb[0]=32'h00000001; vsub[0]=0; vcin[0]=0; es[0]=32'h00000000; ec[0]=1; ev[0]=0; ez[0]=1;
      va[1]=32'h00000005; vb[1]=32'h00000007; vsub[1]=1; vcin[1]=0; es[1]=32'hFFFFFFFE; ec[1]=0; ev[1]=0; ez[1]=0;
      va[2]=32'h80000000; vb[2]=32'h00000001; vsub[2]=1; vcin[2]=0; es[2]=32'h7FFFFFFF; ec[2]=1; ev[2]=1; ez[2]=0;
      va[3]=32'h7FFFFFFF; vb[3]=32'h00000001; vsub[3]=0; vcin[3]=0; es[3]=32'h80000000; ec[3]=0; ev[3]=1; ez[3]=0;
      va[4]=32'h000000FF; vb[4]=32'h00000000; vsub[4]=0; vcin[4]=1; es[4]=32'h00000100; ec[4]=0; ev[4]=0; ez[4]=0;
      va[5]=32'h00000005; vb[5]=32'h00000007; vsub[5]=1; vcin[5]=1; es[5]=32'hFFFFFFFE; ec[5]=0; ev[5]=0; ez[5]=0;
      va[6]=32'h12345678; vb[6]=32'h12345678; vsub[6]=1; vcin[6]=0; es[6]=32'h00000000; ec[6]=1; ev[6]=0; ez[6]=1;
      for (int i = 0; i < 7; i++) begin
         drive_op(2, va[i], vb[i], vsub[i], vcin[i], lat, busyc, stable, s, c, v, z, bd, da);
         checks++;
         if (s !== es[i] || c !== ec[i] || v !== ev[i] || z !== ez[i]) begin
            errors++;
            $display("FAIL vec%0d result: got sum=%h c=%b v=%b z=%b exp sum=%h c=%b v=%b z=%b",
                     i, s, c, v, z, es[i], ec[i], ev[i], ez[i]);
         end
         checks++;
         if (lat !== 4 || busyc !== 4 || bd !== 1'b0) begin
            errors++;
            $display("FAIL vec%0d timing: got lat=%0d busy_cycles=%0d busy_at_done=%b exp 4 4 0",
                     i, lat, busyc, bd);
         end
         checks++;
         if (stable !== 1'b1 || da !== 1'b0) begin
            errors++;
            $display("FAIL vec%0d stable/pulse: got stable=%b done_after=%b exp 1 0", i, stable, da);
         end
      end
   endtask

   task automatic test_start_held();
      logic [31:0] prev_s;
      int dones, late_busy;
      bit stable;
      prev_s     = sum_v[2];
      dones      = 0;
      late_busy  = 0;
      stable     = 1'b1;
      start_v[2] = 1'b1;
      a_v[2]     = 32'd10;
      b_v[2]     = 32'd20;
      sub_v[2]   = 1'b0;
      cin_v[2]   = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done_v[2] === 1'b1) dones++;
         if (busy_v[2] === 1'b1 && sum_v[2] !== prev_s) stable = 1'b0;
         a_v[2]   = $urandom;
         b_v[2]   = $urandom;
         sub_v[2] = 1'($urandom);
      end
      start_v[2] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done_v[2] === 1'b1) dones++;
         if (busy_v[2] === 1'b1) late_busy++;
      end
      checks++;
      if (dones !== 1) begin
         errors++;
         $display("FAIL held_done_count: got %0d exp 1", dones);
      end
      checks++;
      if (sum_v[2] !== 32'd30 || cout_v[2] !== 1'b0) begin
         errors++;
         $display("FAIL held_result: got sum=%h c=%b exp sum=%h c=0", sum_v[2], cout_v[2], 32'd30);
      end
      checks++;
      if (stable !== 1'b1 || late_busy !== 0) begin
         errors++;
         $display("FAIL held_stable: got stable=%b late_busy=%0d exp 1 0", stable, late_busy);
      end
   endtask

   task automatic test_reset_mid();
      int lat, busyc, dones;
      bit stable;
      logic [31:0] s;
      logic c, v, z, bd, da;
      drive_op(2, 32'h00000001, 32'h00000002, 1'b0, 1'b0, lat, busyc, stable, s, c, v, z, bd, da);
      checks++;
      if (s !== 32'h3) begin
         errors++;
         $display("FAIL rstmid_pre: got sum=%h exp %h", s, 32'h3);
      end
      start_v[2] = 1'b1;
      a_v[2]     = 32'hFFFFFFFF;
      b_v[2]     = 32'hFFFFFFFF;
      sub_v[2]   = 1'b0;
      cin_v[2]   = 1'b1;
      @(negedge clk);
      start_v[2] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (busy_v[2] !== 1'b0 || done_v[2] !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_ctrl: got busy=%b done=%b exp 0 0", busy_v[2], done_v[2]);
      end
      checks++;
      if (sum_v[2] !== 32'h0 || cout_v[2] !== 1'b0 || ovf_v[2] !== 1'b0 || zero_v[2] !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_out: got sum=%h c=%b v=%b z=%b exp 0", sum_v[2], cout_v[2],
                  ovf_v[2], zero_v[2]);
      end
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done_v[2] === 1'b1 || busy_v[2] === 1'b1) dones++;
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL rstmid_no_done: got %0d active cycles exp 0", dones);
      end
      drive_op(2, 32'h00000001, 32'h00000001, 1'b0, 1'b0, lat, busyc, stable, s, c, v, z, bd, da);
      checks++;
      if (s !== 32'h2 || lat !== 4) begin
         errors++;
         $display("FAIL rstmid_post: got sum=%h lat=%0d exp sum=%h lat=4", s, lat, 32'h2);
      end
   endtask

   task automatic test_sweep(input int k, input int chunk);
      int nch, lat, busyc;
      bit stable;
      logic [31:0] a, b, s, es;
      logic sub, cin, c, v, z, bd, da, ec, ev, ez;
      nch = 32 / chunk;
      for (int n = 0; n < 1000; n++) begin
         a   = pick_operand();
         b   = pick_operand();
         sub = 1'($urandom);
         cin = 1'($urandom);
         model(a, b, sub, cin, es, ec, ev, ez);
         drive_op(k, a, b, sub, cin, lat, busyc, stable, s, c, v, z, bd, da);
         checks++;
         if (s !== es) begin
            errors++;
            $display("FAIL sweep_c%0d op%0d sum: a=%h b=%h sub=%b cin=%b got %h exp %h",
                     chunk, n, a, b, sub, cin, s, es);
         end
         checks++;
         if (c !== ec || v !== ev || z !== ez) begin
            errors++;
            $display("FAIL sweep_c%0d op%0d flags: a=%h b=%h sub=%b got c=%b v=%b z=%b exp c=%b v=%b z=%b",
                     chunk, n, a, b, sub, c, v, z, ec, ev, ez);
         end
         checks++;
         if (lat !== nch || busyc !== nch || bd !== 1'b0 || da !== 1'b0 || stable !== 1'b1) begin
            errors++;
            $display("FAIL sweep_c%0d op%0d timing: got lat=%0d busy=%0d bd=%b da=%b st=%b exp lat=%0d busy=%0d 0 0 1",
                     chunk, n, lat, busyc, bd, da, stable, nch, nch);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         start_v[k] = 1'b0;
         sub_v[k]   = 1'b0;
         cin_v[k]   = 1'b0;
         a_v[k]     = '0;
         b_v[k]     = '0;
      end
      test_reset();
      test_vectors();
      test_start_held();
      test_reset_mid();
      fork
         test_sweep(0, 1);
         test_sweep(1, 4);
         test_sweep(2, 8);
         test_sweep(3, 32);
      join
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
